// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds owner states, opcodes and the memory request record.
`timescale 1ns/1ps
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RSP_F = 2'd1,
      RSP_D = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0] OP_FETCH = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   typedef struct packed {
      logic [1:0]  op;
      logic [29:0] word;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } mem_req_t;

   localparam int MEM_REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_arbiter_prio.sv
// Two-way fixed-priority selector with a starvation override.
// req_hi normally wins; starve hands the slot to req_lo.
`timescale 1ns/1ps
module arb_prio2 (
   input  logic       req_hi,
   input  logic       req_lo,
   input  logic       starve,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      priority case (1'b1)
         (starve && req_lo): grant = 2'b10;
         req_hi:             grant = 2'b01;
         req_lo:             grant = 2'b10;
         default:            grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data ports onto one word memory.
// One request per cycle; response presented exactly one cycle later.
`timescale 1ns/1ps
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_WORDS    = 1048576,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         f_valid,
   input  logic [31:0]                  f_addr,
   output logic                         f_ready,
   input  logic                         f_flush,
   output logic                         f_rsp_valid,
   output logic [31:0]                  f_rsp_data,
   output logic                         f_rsp_err,
   input  logic                         d_valid,
   input  logic                         d_we,
   input  logic [31:0]                  d_addr,
   input  logic [31:0]                  d_wdata,
   input  logic [3:0]                   d_wstrb,
   output logic                         d_ready,
   output logic                         d_rsp_valid,
   output logic                         d_rsp_err,
   output logic [31:0]                  d_rsp_data,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [3:0]                   mem_wstrb,
   input  logic [31:0]                  mem_rdata
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        state;
   logic [1:0]    op;
   logic          err;
   logic [SW-1:0] starve_cnt;
   logic          starve;
   logic          oob;
   logic          acc;
   logic [1:0]    grant;
   mem_req_t      req;
   logic          unused_lsb;

   assign unused_lsb = ^{f_addr[1:0], d_addr[1:0]};
   assign starve = (starve_cnt == SW'(STARVE_LIMIT));

   arb_prio2 u_arb (
      .req_hi (reset & d_valid),
      .req_lo (reset & f_valid & ~f_flush),
      .starve (starve),
      .grant  (grant)
   );

   assign d_ready = grant[0];
   assign f_ready = grant[1];
   assign acc     = |grant;

   always_comb begin
      req = '0;
      if (grant[1]) begin
         req.op   = OP_FETCH;
         req.word = f_addr[31:2];
      end else if (grant[0]) begin
         req.op    = d_we ? OP_STORE : OP_LOAD;
         req.word  = d_addr[31:2];
         req.wdata = d_wdata;
         req.strb  = d_we ? d_wstrb : 4'h0;
      end
   end

   // Out-of-range requests are still accepted, just never reach memory.
   assign oob       = ({2'b00, req.word} >= 32'(MEM_WORDS));
   assign mem_en    = acc & ~oob;
   assign mem_we    = mem_en & (req.op == OP_STORE);
   assign mem_addr  = req.word[AW-1:0];
   assign mem_wdata = req.wdata;
   assign mem_wstrb = mem_we ? req.strb : 4'h0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         op         <= OP_FETCH;
         err        <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state <= grant[1] ? RSP_F : (grant[0] ? RSP_D : IDLE);
         op    <= req.op;
         err   <= acc & oob;
         if (!f_valid || grant[1])
            starve_cnt <= '0;
         else if (grant[0] && !starve)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Response outputs use mem_rdata directly: it lands in the response cycle.
   assign f_rsp_valid = reset & (state == RSP_F) & ~f_flush;
   assign f_rsp_err   = f_rsp_valid & err;
   assign f_rsp_data  = !f_rsp_valid ? 32'h0 :
                        (err ? NOP_INSTR : mem_rdata);

   assign d_rsp_valid = reset & (state == RSP_D);
   assign d_rsp_err   = d_rsp_valid & err;
   assign d_rsp_data  = (d_rsp_valid && !err && op == OP_LOAD) ?
                        mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized plus directed bench for mem_arbiter against a
// transaction-level model with its own shadow memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int MEM_WORDS    = 1048576;
   localparam int STARVE_LIMIT = 4;
   localparam int AW           = $clog2(MEM_WORDS);

   logic          clock = 1'b0;
   logic          reset;
   logic          f_valid, f_flush;
   logic [31:0]   f_addr;
   logic          f_ready, f_rsp_valid, f_rsp_err;
   logic [31:0]   f_rsp_data;
   logic          d_valid, d_we;
   logic [31:0]   d_addr, d_wdata;
   logic [3:0]    d_wstrb;
   logic          d_ready, d_rsp_valid, d_rsp_err;
   logic [31:0]   d_rsp_data;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_arbiter #(
      .MEM_WORDS    (MEM_WORDS),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .f_valid     (f_valid),
      .f_addr      (f_addr),
      .f_ready     (f_ready),
      .f_flush     (f_flush),
      .f_rsp_valid (f_rsp_valid),
      .f_rsp_data  (f_rsp_data),
      .f_rsp_err   (f_rsp_err),
      .d_valid     (d_valid),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_wstrb     (d_wstrb),
      .d_ready     (d_ready),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_err   (d_rsp_err),
      .d_rsp_data  (d_rsp_data),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_rdata   (mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory environment driven by the DUT's memory port.
   logic [31:0] env_mem [int];
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] env_rd(input int k);
      return env_mem.exists(k) ? env_mem[k] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input int k);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we)
            env_mem[int'(mem_addr)] = merge(env_rd(int'(mem_addr)),
                                            mem_wdata, mem_wstrb);
         else
            mem_rdata <= env_rd(int'(mem_addr));
      end
   end

   // Reference model: grants, memory issue and one pending response.
   int          m_starve = 0;
   bit          m_fgnt = 0, m_dgnt = 0;
   bit          p_valid = 0, p_fetch = 0, p_err = 0;
   logic [31:0] p_data = 0;
   bit          eg_f, eg_d, in_b, e_en, e_we, e_fv, e_dv;
   logic [31:0] a;

   always @(negedge clock) begin
      eg_f = 0;
      eg_d = 0;
      if (reset === 1'b1) begin
         if (f_valid && !f_flush && (!d_valid || m_starve == STARVE_LIMIT))
            eg_f = 1;
         else if (d_valid)
            eg_d = 1;
      end
      a    = eg_f ? f_addr : d_addr;
      in_b = (a >> 2) < MEM_WORDS;
      e_en = (eg_f || eg_d) && in_b;
      e_we = e_en && eg_d && d_we;
      chk("f_ready", 32'(f_ready), 32'(eg_f));
      chk("d_ready", 32'(d_ready), 32'(eg_d));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      if (e_en) chk("mem_addr", 32'(mem_addr), a >> 2);
      if (e_we) begin
         chk("mem_wstrb", 32'(mem_wstrb), 32'(d_wstrb));
         chk("mem_wdata", mem_wdata, d_wdata);
      end
      e_fv = reset && p_valid && p_fetch && !f_flush;
      e_dv = reset && p_valid && !p_fetch;
      chk("f_rsp_valid", 32'(f_rsp_valid), 32'(e_fv));
      chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_dv));
      if (e_fv) begin
         chk("f_rsp_err", 32'(f_rsp_err), 32'(p_err));
         chk("f_rsp_data", f_rsp_data, p_data);
      end
      if (e_dv) begin
         chk("d_rsp_err", 32'(d_rsp_err), 32'(p_err));
         chk("d_rsp_data", d_rsp_data, p_data);
      end
      if (reset !== 1'b1) begin
         m_starve = 0;
         p_valid  = 0;
      end else begin
         p_valid = eg_f || eg_d;
         p_fetch = eg_f;
         p_err   = !in_b;
         if (!in_b)         p_data = eg_f ? 32'h0000_0013 : 32'h0;
         else if (eg_d && d_we) p_data = 32'h0;
         else               p_data = ref_rd(int'(a >> 2));
         if (e_we)
            ref_mem[int'(a >> 2)] = merge(ref_rd(int'(a >> 2)), d_wdata, d_wstrb);
         if (eg_f || !f_valid)  m_starve = 0;
         else if (eg_d && m_starve < STARVE_LIMIT) m_starve++;
      end
      m_fgnt = eg_f;
      m_dgnt = eg_d;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      f_valid = 0; f_flush = 0; f_addr = 0;
      d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
   endtask

   task automatic preset(input int k, input logic [31:0] v);
      env_mem[k] = v;
      ref_mem[k] = v;
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(9) == 0)
         return 32'h0040_0000 | 32'($urandom);
      return (32'($urandom_range(255)) << 2) | 32'($urandom_range(3));
   endfunction

   initial begin
      reset = 0;
      idle();
      f_valid = 1;
      d_valid = 1;
      preset(0, 32'hA000_0001);
      preset(1, 32'hA000_0002);
      preset(2, 32'hA000_0003);
      repeat (2) begin
         @(negedge clock);
         chk("rst_f_ready", 32'(f_ready), 0);
         chk("rst_d_ready", 32'(d_ready), 0);
         chk("rst_mem_en", 32'(mem_en), 0);
         chk("rst_rsp", 32'({f_rsp_valid, d_rsp_valid}), 0);
         step();
      end
      reset = 1;
      idle();
      // Fetch-only stream
      f_valid = 1; f_addr = 32'h0;
      @(negedge clock); chk("fs_rdy0", 32'(f_ready), 1);
      step(); f_addr = 32'h4;
      @(negedge clock); chk("fs_rdy1", 32'(f_ready), 1);
      chk("fs_dat0", f_rsp_data, 32'hA000_0001);
      step(); f_addr = 32'h8;
      @(negedge clock); chk("fs_dat1", f_rsp_data, 32'hA000_0002);
      step(); idle();
      @(negedge clock); chk("fs_dat2", f_rsp_data, 32'hA000_0003);
      step();
      // Contention: four data grants then one fetch
      f_valid = 1; f_addr = 32'h20;
      d_valid = 1; d_addr = 32'h10;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         chk("cont_f", 32'(f_ready), 32'(i % 5 == 4));
         chk("cont_d", 32'(d_ready), 32'(i % 5 != 4));
         step();
      end
      idle();
      step();
      // Partial store then load back
      d_valid = 1; d_we = 1; d_addr = 32'h100;
      d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      @(negedge clock);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", 32'(mem_addr), 32'h40);
      chk("st_strb", 32'(mem_wstrb), 32'h3);
      step(); d_we = 0; d_wstrb = 0;
      @(negedge clock); chk("st_rsp", d_rsp_data, 32'h0);
      step(); idle();
      @(negedge clock); chk("ld_dat", d_rsp_data, 32'h0000_BEEF);
      step();
      // Out-of-range fetch
      f_valid = 1; f_addr = 32'h0040_0000;
      @(negedge clock);
      chk("oob_en", 32'(mem_en), 0);
      chk("oob_rdy", 32'(f_ready), 1);
      step(); idle();
      @(negedge clock);
      chk("oob_v", 32'(f_rsp_valid), 1);
      chk("oob_err", 32'(f_rsp_err), 1);
      chk("oob_dat", f_rsp_data, 32'h0000_0013);
      step();
      // Flush in the response cycle
      f_valid = 1; f_addr = 32'h8;
      @(negedge clock);
      step(); f_addr = 32'hC; f_flush = 1; d_valid = 1; d_addr = 32'h0;
      @(negedge clock);
      chk("fl_rspv", 32'(f_rsp_valid), 0);
      chk("fl_frdy", 32'(f_ready), 0);
      chk("fl_drdy", 32'(d_ready), 1);
      step(); idle();
      @(negedge clock); chk("fl_ddat", d_rsp_data, 32'hA000_0001);
      step();
      // Reset in the response cycle of a load
      d_valid = 1; d_addr = 32'h4;
      @(negedge clock);
      step(); idle(); reset = 0;
      @(negedge clock); chk("rr_v0", 32'(d_rsp_valid), 0);
      step(); reset = 1;
      @(negedge clock); chk("rr_v1", 32'(d_rsp_valid), 0);
      d_valid = 1; d_addr = 32'h8;
      step(); idle();
      @(negedge clock);
      chk("rr_v2", 32'(d_rsp_valid), 1);
      chk("rr_dat", d_rsp_data, 32'hA000_0003);
      step();
      // Randomized traffic, requests held until granted
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(99) != 0);
         if (!f_valid || m_fgnt) begin
            f_valid = ($urandom_range(99) < 60);
            f_addr  = rnd_addr();
         end
         if (!d_valid || m_dgnt) begin
            d_valid = ($urandom_range(99) < 60);
            d_we    = 1'($urandom_range(1));
            d_addr  = rnd_addr();
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
         end
         f_flush = ($urandom_range(9) == 0);
         step();
      end
      idle();
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 1048576: depth of the shared word memory.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch waits.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 f_valid  in  1  fetch request valid.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_ready  out  1  fetch request accepted this cycle.
REQ-008 f_flush  in  1  pipeline flush: drop outstanding fetch response.
REQ-009 f_rsp_valid  out  1  fetch response valid, one cycle.
REQ-010 f_rsp_data  out  32  fetched instruction word.
REQ-011 f_rsp_err  out  1  fetch address out of bounds.
REQ-012 d_valid, d_we  in  1 each  data request valid; 1 = store, 0 = load.
REQ-013 d_addr, d_wdata  in  32 each  data byte address and store data.
REQ-014 d_wstrb  in  4  store byte enables.
REQ-015 d_ready  out  1  data request accepted this cycle.
REQ-016 d_rsp_valid, d_rsp_err  out  1 each  data response valid; out-of-bounds flag.
REQ-017 d_rsp_data  out  32  load data (0 for stores).
REQ-018 mem_en, mem_we  out  1 each  memory access enable; write enable.
REQ-019 mem_addr  out  $clog2(MEM_WORDS)  word index (byte address >> 2).
REQ-020 mem_wdata, mem_wstrb  out  32, 4  write data and byte strobes.
REQ-021 mem_rdata  in  32  read data, valid exactly one cycle after mem_en.

Function
REQ-022 Acceptance occurs on valid && ready; at most one of f_ready/d_ready SHALL be high per cycle; ready is combinational from valid, flush and arbiter state.
REQ-023 Arbitration: data wins over fetch, unless starve_cnt == STARVE_LIMIT and f_valid, in which case fetch wins.
REQ-024 starve_cnt increments on each data grant while f_valid is high, clears on a fetch grant or while f_valid is low, and saturates at STARVE_LIMIT.
REQ-025 On acceptance the memory access issues in the same cycle: mem_en=1, mem_addr=addr[31:2]; for stores mem_we=1 and mem_wstrb=d_wstrb, otherwise mem_we=0 and mem_wstrb=0.
REQ-026 addr[1:0] SHALL be ignored (word access only).
REQ-027 The response SHALL be asserted exactly one cycle after acceptance on the accepting port's rsp_valid, with rsp_data = mem_rdata (loads/fetch) or 0 (stores).
REQ-028 There is no response backpressure; a new acceptance is allowed in the response cycle, so throughput is one request per cycle.
REQ-029 Owner FSM: IDLE, RSP_F, RSP_D; next state = RSP_F or RSP_D on a fetch or data acceptance, else IDLE.
REQ-030 An address with addr >= MEM_WORDS*4 SHALL give mem_en=0 and, one cycle later, rsp_err=1; f_rsp_data = 32'h00000013 (NOP), d_rsp_data = 0; stores are discarded.
REQ-031 f_flush=1 forces f_ready=0 that cycle (data may still be granted).
REQ-032 f_flush=1 while the state is RSP_F suppresses f_rsp_valid that cycle.
REQ-033 f_flush has no effect on data requests or data responses.
REQ-034 Requesters SHALL hold valid/addr stable until accepted; the arbiter never drops an unaccepted request.

Reset
REQ-035 While reset=0 at a clock edge: state=IDLE, starve_cnt=0, all rsp_valid/rsp_err=0, rsp_data=0.
REQ-036 While reset=0: f_ready=d_ready=0 and mem_en=mem_we=0 combinationally.
REQ-037 An outstanding response in flight at reset is dropped and never presented.
REQ-038 First acceptance is possible in the first cycle with reset=1.

Structure
REQ-039 The shared package SHALL hold the FSM state enum, NOP_INSTR = 32'h00000013, the opcode localparams, and the width of the memory request record.
REQ-040 The priority/starvation selector SHALL be one sub-module, arb_prio2 (inputs: two valids, starve flag; output: one-hot grant).
REQ-041 Memory storage SHALL stay outside this block.

Verification
REQ-042 Fetch-only stream: f_valid continuous, addrs 0,4,8 -> f_ready every cycle, f_rsp_data = mem[0..2] one cycle after each acceptance.
REQ-043 Contention, STARVE_LIMIT=4: f_valid and d_valid held high -> 4 data grants, 1 fetch grant, repeating; no fetch waits more than 5 cycles.
REQ-044 Store 0xDEADBEEF, wstrb=4'b0011, to 0x100, then load 0x100 -> mem_we pulse at word 0x40; load returns 0x0000BEEF over memory preset 0.
REQ-045 Fetch at 0x00400000 with MEM_WORDS=1048576 -> mem_en=0; next cycle f_rsp_valid=1, f_rsp_err=1, f_rsp_data=0x00000013.
REQ-046 Fetch accepted, f_flush=1 in the following cycle -> f_rsp_valid stays 0, f_ready=0; a simultaneous d_valid is granted normally.
REQ-047 reset=0 asserted in the cycle after a load is accepted -> d_rsp_valid never rises; after release, the first request completes normally.
